// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared state type and default sizing for the clock period meter
package clk_meas_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int LOCK_CNT_DEF = 4;
  typedef enum logic {IDLE, MEASURE} state_e;
endpackage

// File: rtl/sig_edge_sync.sv
// sig_edge_sync: 2-flop synchronizer plus edge register emitting rise (and, with CLK_PERIOD_METER_DUTY_EN, fall) pulses
module sig_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
`ifdef CLK_PERIOD_METER_DUTY_EN
  ,
  output logic fall_o
`endif
);
  logic s1_q, s2_q, lvl_q, rise_q;
  // synchronize the level, keep the previous synchronized level, register the rising-edge pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      lvl_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      lvl_q <= s2_q;
      rise_q <= s2_q & ~lvl_q;
    end
  end
  assign rise_o = rise_q;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic fall_q;
  // falling-edge pulse, aligned with the rising-edge pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) fall_q <= 1'b0;
    else fall_q <= ~s2_q & lvl_q;
  end
  assign fall_o = fall_q;
`endif
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period, high time and lock of slow sig_in in clk_in cycles; CLK_PERIOD_METER_DUTY_EN enables high time
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [3:0] match_q, match_d;
  logic valid_q, valid_d, locked_q, locked_d, ovf_q, ovf_d, rise, meas;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic fall;
  sig_edge_sync u_sync (.clk_i(clk_in), .rst_i(rst), .sig_i(sig_in), .rise_o(rise), .fall_o(fall));
`else
  sig_edge_sync u_sync (.clk_i(clk_in), .rst_i(rst), .sig_i(sig_in), .rise_o(rise));
`endif
  assign meas = (state_q == MEASURE) && rise;
  // count between rising edges; an edge beats saturation, saturation without an edge aborts to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    period_d = period_q;
    valid_d = 1'b0;
    match_d = match_q;
    locked_d = locked_q;
    ovf_d = ovf_q;
    if (rise) begin
      state_d = MEASURE;
      cnt_d = CNT_W'(1);
    end else if (state_q == MEASURE && cnt_q == CNT_MAX) begin
      state_d = IDLE;
      cnt_d = '0;
      ovf_d = 1'b1;
      locked_d = 1'b0;
      match_d = '0;
    end else if (state_q == MEASURE) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (meas) begin
      period_d = cnt_q;
      valid_d = 1'b1;
      match_d = (cnt_q == period_q) ? ((match_q == LOCK_N) ? LOCK_N : match_q + 4'd1) : 4'd1;
      locked_d = (match_d == LOCK_N);
      ovf_d = 1'b0;
    end
  end
  // state, counter and result registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      period_q <= '0;
      valid_q <= 1'b0;
      match_q <= '0;
      locked_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      valid_q <= valid_d;
      match_q <= match_d;
      locked_q <= locked_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hi_q, hi_d, high_q, high_d;
  logic fell_q, fell_d;
  // latch the count at the falling edge; a period without one reports its full length
  always_comb begin
    hi_d = (state_q == MEASURE && fall && !rise) ? cnt_q : hi_q;
    fell_d = (state_q == MEASURE && !rise) ? (fell_q | fall) : 1'b0;
    high_d = meas ? (fell_q ? hi_q : cnt_q) : high_q;
  end
  // high-time registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hi_q <= '0;
      high_q <= '0;
      fell_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      high_q <= high_d;
      fell_q <= fell_d;
    end
  end
  assign high_time = high_q;
`else
  assign high_time = '0;
`endif
  assign period = period_q;
  assign meas_valid = valid_q;
  assign locked = locked_q;
  assign overflow = ovf_q;
endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period and high-time counters and outputs (minimum 4).
REQ-002 SHALL have parameter LOCK_CNT, default 4, number of consecutive identical periods required for lock (range 2..15).
REQ-003 SHALL have port clk_in  input  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sig_in  input  1  divided/slow clock under measurement, asynchronous to clk_in.
REQ-006 SHALL have port period  output  CNT_W  last measured period, in clk_in cycles, between synchronized rising edges.
REQ-007 SHALL have port high_time  output  CNT_W  last measured high time, in clk_in cycles.
REQ-008 SHALL have port meas_valid  output  1  one-cycle pulse when period and high_time update.
REQ-009 SHALL have port locked  output  1  high while LOCK_CNT or more consecutive equal periods have been seen.
REQ-010 SHALL have port overflow  output  1  sticky flag for a period that exceeded the counter range.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer and an edge register; a rising or falling edge is flagged 3 clk_in posedges after the posedge that first samples the new level.
REQ-012 SHALL implement states IDLE (wait for first rising edge) and MEASURE; IDLE->MEASURE on rising edge, with no measurement reported.
REQ-013 In MEASURE, SHALL load the cycle counter with 1 on each rising edge and increment it by 1 on every other cycle.
REQ-014 On a rising edge in MEASURE, SHALL load period with the counter value (pre-reload), load high_time, and pulse meas_valid for exactly one cycle.
REQ-015 SHALL latch the high-time count on the falling edge (counter value at that cycle); a period with no falling edge SHALL report high_time equal to period.
REQ-016 SHALL saturate the counter at 2^CNT_W-1; on reaching it without a rising edge, SHALL set overflow, clear locked, suppress meas_valid, and return to IDLE.
REQ-017 If a rising edge coincides with the counter at 2^CNT_W-1, the edge SHALL win: valid measurement with period = 2^CNT_W-1 and no overflow.
REQ-018 SHALL clear overflow on the next meas_valid.
REQ-019 SHALL keep a match counter: increment (saturating at LOCK_CNT) when the new period equals the previous one, else reload with 1; locked = (match counter == LOCK_CNT), updated in the meas_valid cycle.
REQ-020 SHALL hold period and high_time stable between meas_valid pulses.

Reset
REQ-021 On rst, SHALL set period=0, high_time=0, meas_valid=0, locked=0, overflow=0, state=IDLE, counters and synchronizer flops=0.
REQ-022 rst asserted mid-measurement SHALL discard the partial measurement; the first rising edge after release only arms MEASURE.

Configuration
REQ-023 Macro CLK_PERIOD_METER_DUTY_EN: defined -> high-time measurement per REQ-015; undefined -> falling-edge logic omitted and high_time tied to 0; period, lock and overflow behaviour unchanged.

Structure
REQ-024 SHALL place the state enum type and default CNT_W/LOCK_CNT constants in shared package clk_meas_pkg.
REQ-025 SHALL instantiate sub-module sig_edge_sync (2-flop sync + edge register, outputs rise/fall pulses); all remaining logic inline.

Verification
REQ-026 sig_in synchronous pattern high 3 / low 2 cycles, repeated -> period=5, high_time=3 from the 2nd rising edge on; locked rises on the LOCK_CNT-th valid (5th rising edge with default 4).
REQ-027 Locked at period 5, one period stretched to 7 -> meas_valid with period=7, locked=0 in that cycle; relock after 4 further equal periods.
REQ-028 CNT_W=4, sig_in held low after arming -> overflow=1 at count 15, no meas_valid, state IDLE; next two rising edges -> valid measurement, overflow cleared.
REQ-029 rst pulsed 2 cycles into a period-5 pattern -> all outputs 0; first meas_valid only at the second rising edge after release.
REQ-030 Macro undefined, same pattern as REQ-026 -> period=5, high_time=0; sig_in held high for a whole period with macro defined -> high_time=period.
